// File: rtl/i2s_rx_stereo.sv
// rtl/i2s_rx_stereo.sv - I2S bus master receiver producing stereo pairs with valid/ready handoff.
// Optional macro I2S_RX_OVERRUN_CNT_EN adds a saturating 16-bit overrun_cnt output.
module i2s_rx_stereo #(
  parameter int CLK_DIV_HALF = 50,
  parameter int SLOT_BITS    = 32,
  parameter int SAMPLE_BITS  = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sd,
  output logic                   bclk,
  output logic                   lrclk,
  output logic [SAMPLE_BITS-1:0] out_left,
  output logic [SAMPLE_BITS-1:0] out_right,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef I2S_RX_OVERRUN_CNT_EN
  output logic                   overrun,
  output logic [15:0]            overrun_cnt
`else
  output logic                   overrun
`endif
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = $clog2(CLK_DIV_HALF);
  localparam int CNT_W      = $clog2(FRAME_BITS);

  logic [DIV_W-1:0]       div_q, div_d;
  logic                   bclk_q, bclk_d;
  logic                   lrclk_q, lrclk_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SAMPLE_BITS-1:0] shift_q, shift_d;
  logic [SAMPLE_BITS-1:0] left_q, left_d;
  logic [SAMPLE_BITS-1:0] out_left_q, out_left_d;
  logic [SAMPLE_BITS-1:0] out_right_q, out_right_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overrun_q, overrun_d;

  logic                   div_wrap;
  logic                   rise_evt;
  logic                   fall_evt;
  logic [CNT_W-1:0]       cnt_inc;
  logic [CNT_W-1:0]       slot_pos;
  logic                   shift_en;
  logic                   word_done;
  logic [SAMPLE_BITS-1:0] shift_next;

  assign div_wrap   = (div_q == DIV_W'(CLK_DIV_HALF - 1));
  assign rise_evt   = div_wrap & ~bclk_q;
  assign fall_evt   = div_wrap & bclk_q;
  assign cnt_inc    = (cnt_q == CNT_W'(FRAME_BITS - 1)) ? '0 : cnt_q + 1'b1;
  assign slot_pos   = (cnt_q >= CNT_W'(SLOT_BITS)) ? cnt_q - CNT_W'(SLOT_BITS) : cnt_q;
  // Position 0 is the one-bit I2S delay; trailing slot bits past the sample are padding.
  assign shift_en   = rise_evt && (slot_pos != '0) && (slot_pos <= CNT_W'(SAMPLE_BITS));
  assign word_done  = rise_evt && (slot_pos == CNT_W'(SAMPLE_BITS));
  assign shift_next = {shift_q[SAMPLE_BITS-2:0], sd};

  always_comb begin
    div_d       = div_wrap ? '0 : div_q + 1'b1;
    bclk_d      = div_wrap ? ~bclk_q : bclk_q;
    cnt_d       = cnt_q;
    lrclk_d     = lrclk_q;
    shift_d     = shift_en ? shift_next : shift_q;
    left_d      = left_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    out_valid_d = out_valid_q;
    overrun_d   = 1'b0;

    if (fall_evt) begin
      cnt_d   = cnt_inc;
      lrclk_d = (cnt_inc >= CNT_W'(SLOT_BITS));
    end

    if (word_done && !lrclk_q) begin
      left_d = shift_next;
    end

    // A finished right word closes the pair; it loads unless the presented pair is still stalled.
    if (word_done && lrclk_q) begin
      if (!out_valid_q || out_ready) begin
        out_left_d  = left_q;
        out_right_d = shift_next;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q       <= '0;
      bclk_q      <= 1'b0;
      lrclk_q     <= 1'b1;
      cnt_q       <= CNT_W'(FRAME_BITS - 1);
      shift_q     <= '0;
      left_q      <= '0;
      out_left_q  <= '0;
      out_right_q <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      lrclk_q     <= lrclk_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      left_q      <= left_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bclk      = bclk_q;
  assign lrclk     = lrclk_q;
  assign out_left  = out_left_q;
  assign out_right = out_right_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

`ifdef I2S_RX_OVERRUN_CNT_EN
  logic [15:0] ocnt_q, ocnt_d;

  always_comb begin
    ocnt_d = ocnt_q;
    if (overrun_d && (ocnt_q != 16'hFFFF)) begin
      ocnt_d = ocnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ocnt_q <= '0;
    end else begin
      ocnt_q <= ocnt_d;
    end
  end

  assign overrun_cnt = ocnt_q;
`endif

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// tb/tb_i2s_rx_stereo.sv - directed bench for i2s_rx_stereo (32-bit and 16-bit slot builds).
module tb_i2s_rx_stereo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sd = 1'b1;
  logic sd2 = 1'b1;
  logic out_ready = 1'b1;
  logic out_ready2 = 1'b1;
  logic bclk, lrclk, out_valid, overrun;
  logic bclk2, lrclk2, out_valid2, overrun2;
  logic [23:0] out_left, out_right;
  logic [14:0] out_left2, out_right2;
`ifdef I2S_RX_OVERRUN_CNT_EN
  logic [15:0] ocnt, ocnt2;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int ecount = 0;
  int ov_seen = 0;
  int fidx = -1;
  int fidx2 = -1;
  logic [23:0] lw[16];
  logic [23:0] rw[16];
  logic [14:0] lw2[16];
  logic [14:0] rw2[16];

  always #5 clk = ~clk;

  i2s_rx_stereo #(.CLK_DIV_HALF(2), .SLOT_BITS(32), .SAMPLE_BITS(24)) u_dut (
    .clk(clk), .rst(rst), .sd(sd), .bclk(bclk), .lrclk(lrclk),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef I2S_RX_OVERRUN_CNT_EN
    .overrun(overrun), .overrun_cnt(ocnt)
`else
    .overrun(overrun)
`endif
  );

  i2s_rx_stereo #(.CLK_DIV_HALF(2), .SLOT_BITS(16), .SAMPLE_BITS(15)) u_dut16 (
    .clk(clk), .rst(rst), .sd(sd2), .bclk(bclk2), .lrclk(lrclk2),
    .out_left(out_left2), .out_right(out_right2), .out_valid(out_valid2),
    .out_ready(out_ready2),
`ifdef I2S_RX_OVERRUN_CNT_EN
    .overrun(overrun2), .overrun_cnt(ocnt2)
`else
    .overrun(overrun2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step_to(input int e);
    while (ecount < e) begin
      @(posedge clk);
      #1;
      ecount++;
    end
  endtask

  // Codec models: change sd after each bclk fall, one-bit delay after lrclk edge, 1s as filler.
  initial begin : codec32
    logic pb, pl;
    int pos;
    logic [23:0] w;
    pb = 1'b0; pl = 1'b1; pos = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pb = 1'b0; pl = 1'b1; pos = 0; sd = 1'b1;
      end else begin
        if (pb && !bclk) begin
          if (lrclk != pl) begin
            pos = 0;
            if (!lrclk) fidx++;
          end else begin
            pos++;
          end
        end
        pb = bclk; pl = lrclk;
        w = lrclk ? rw[fidx & 15] : lw[fidx & 15];
        sd = (fidx >= 0 && pos >= 1 && pos <= 24) ? w[24 - pos] : 1'b1;
      end
    end
  end

  initial begin : codec16
    logic pb, pl;
    int pos;
    logic [14:0] w;
    pb = 1'b0; pl = 1'b1; pos = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pb = 1'b0; pl = 1'b1; pos = 0; sd2 = 1'b1;
      end else begin
        if (pb && !bclk2) begin
          if (lrclk2 != pl) begin
            pos = 0;
            if (!lrclk2) fidx2++;
          end else begin
            pos++;
          end
        end
        pb = bclk2; pl = lrclk2;
        w = lrclk2 ? rw2[fidx2 & 15] : lw2[fidx2 & 15];
        sd2 = (fidx2 >= 0 && pos >= 1 && pos <= 15) ? w[15 - pos] : 1'b1;
      end
    end
  end

  initial begin : ov_mon
    forever begin
      @(negedge clk);
      if (overrun === 1'b1) ov_seen++;
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      lw[i] = 24'h5A5A5A; rw[i] = 24'hA5A5A5;
      lw2[i] = 15'h2AAA;  rw2[i] = 15'h1555;
    end
    lw[0] = 24'hABCDEF; rw[0] = 24'h123456;
    lw[1] = 24'h111111; rw[1] = 24'h222222;
    lw[2] = 24'h333333; rw[2] = 24'h444444;
    lw[3] = 24'h555555; rw[3] = 24'h666666;
    lw[4] = 24'h0A0A0A; rw[4] = 24'h0B0B0B;
    lw[5] = 24'h0C0C0C; rw[5] = 24'h0D0D0D;
    lw[6] = 24'h777777; rw[6] = 24'h888888;
    lw[7] = 24'h000001; rw[7] = 24'hFFFFFF;
    lw2[0] = 15'h4001;  rw2[0] = 15'h7FFE;

    repeat (3) @(posedge clk);
    #1;
    check("rst_bclk", bclk, 0);
    check("rst_lrclk", lrclk, 1);
    check("rst_valid", out_valid, 0);
    check("rst_left", out_left, 0);
    check("rst_right", out_right, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    ecount = 0;

    step_to(1);   check("bclk_e1", bclk, 0);
    step_to(2);   check("bclk_e2", bclk, 1); check("lrclk_e2", lrclk, 1);
    step_to(3);   check("lrclk_e3", lrclk, 1);
    step_to(4);   check("lrclk_e4", lrclk, 0); check("bclk_e4", bclk, 0);
    step_to(6);   check("bclk_e6", bclk, 1);
    step_to(131); check("lrclk_e131", lrclk, 0);
    step_to(132); check("lrclk_e132", lrclk, 1);

    step_to(229); check("p0_valid_pre", out_valid, 0);
    step_to(230); check("p0_valid", out_valid, 1);
    check("p0_left", out_left, 24'hABCDEF);
    check("p0_right", out_right, 24'h123456);
    step_to(231); check("p0_valid_post", out_valid, 0);
    step_to(259); check("lrclk_e259", lrclk, 1);
    step_to(260); check("lrclk_e260", lrclk, 0);

    step_to(300); out_ready = 1'b0;
    step_to(486); check("a_valid", out_valid, 1);
    check("a_left", out_left, 24'h111111);
    check("a_right", out_right, 24'h222222);
    step_to(742); check("b_overrun", overrun, 1); check("b_keep_left", out_left, 24'h111111);
    step_to(743); check("b_overrun_end", overrun, 0); check("b_valid", out_valid, 1);
    step_to(998); check("c_overrun", overrun, 1); check("c_keep_right", out_right, 24'h222222);
    step_to(999); check("c_overrun_end", overrun, 0);
    check("ov_pulses", ov_seen, 2);
`ifdef I2S_RX_OVERRUN_CNT_EN
    check("ov_cnt", ocnt, 2);
`endif
    step_to(1099); check("a_held", out_valid, 1); check("a_held_left", out_left, 24'h111111);
    out_ready = 1'b1;
    step_to(1100); check("a_accepted", out_valid, 0);
    out_ready = 1'b0;

    step_to(1254); check("x_valid", out_valid, 1);
    check("x_left", out_left, 24'h0A0A0A);
    check("x_right", out_right, 24'h0B0B0B);
    step_to(1509); check("x_held", out_left, 24'h0A0A0A);
    out_ready = 1'b1;
    step_to(1510); check("y_valid", out_valid, 1);
    check("y_left", out_left, 24'h0C0C0C);
    check("y_right", out_right, 24'h0D0D0D);
    check("y_overrun", overrun, 0);
    out_ready = 1'b0;
    step_to(1511); check("y_held", out_valid, 1); check("y_held_left", out_left, 24'h0C0C0C);
    check("ov_pulses_after", ov_seen, 2);

    step_to(1710); check("mid_right_slot", lrclk, 1);
    rst = 1'b1; fidx = 6; fidx2 = -1;
    step_to(1711);
    check("rst2_valid", out_valid, 0);
    check("rst2_left", out_left, 0);
    check("rst2_right", out_right, 0);
    check("rst2_bclk", bclk, 0);
    check("rst2_lrclk", lrclk, 1);
    check("rst2_overrun", overrun, 0);
    check("rst2_valid16", out_valid2, 0);
`ifdef I2S_RX_OVERRUN_CNT_EN
    check("rst2_ov_cnt", ocnt, 0);
`endif
    rst = 1'b0; out_ready = 1'b1;
    ecount = 0;

    step_to(129); check("s16_valid_pre", out_valid2, 0);
    step_to(130); check("s16_valid", out_valid2, 1);
    check("s16_left", out_left2, 15'h4001);
    check("s16_right", out_right2, 15'h7FFE);
    step_to(229); check("r_valid_pre", out_valid, 0);
    step_to(230); check("r_valid", out_valid, 1);
    check("r_left", out_left, 24'h000001);
    check("r_right", out_right, 24'hFFFFFF);
    step_to(231); check("r_valid_post", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_rx_stereo.md
I2S_RX_STEREO -- requirements
Module: i2s_rx_stereo

Interface
REQ-001 SHALL provide parameter CLK_DIV_HALF, default 50, meaning clk cycles per bclk half-period (>=2).
REQ-002 SHALL provide parameter SLOT_BITS, default 32, meaning bclk periods per channel slot (16..64).
REQ-003 SHALL provide parameter SAMPLE_BITS, default 24, meaning captured bits per channel (8..SLOT_BITS-1).
REQ-004 SHALL provide port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL provide port rst  input  1  synchronous active-high reset.
REQ-006 SHALL provide port sd  input  1  I2S serial data from the codec.
REQ-007 SHALL provide port bclk  output  1  generated bit clock.
REQ-008 SHALL provide port lrclk  output  1  generated word select; 0 = left slot, 1 = right slot.
REQ-009 SHALL provide port out_left  output  SAMPLE_BITS  left sample of the presented pair.
REQ-010 SHALL provide port out_right  output  SAMPLE_BITS  right sample of the presented pair.
REQ-011 SHALL provide port out_valid  output  1  stereo pair presented.
REQ-012 SHALL provide port out_ready  input  1  consumer accepts the pair when high with out_valid.
REQ-013 SHALL provide port overrun  output  1  one-cycle pulse when a completed pair is dropped.

Function
REQ-014 The divider SHALL count 0..CLK_DIV_HALF-1 and toggle bclk on wrap; wrap with bclk=0 is rise_evt, wrap with bclk=1 is fall_evt.
REQ-015 The frame counter (0..2*SLOT_BITS-1) SHALL increment modulo 2*SLOT_BITS on each fall_evt; on the same cycle lrclk SHALL become 1 when the new count is >= SLOT_BITS, else 0.
REQ-016 On rise_evt, slot position p = count mod SLOT_BITS; p=0 is the I2S delay bit and SHALL be ignored; p=1..SAMPLE_BITS SHALL shift sd MSB-first; p>SAMPLE_BITS SHALL be ignored.
REQ-017 On rise_evt at p=SAMPLE_BITS the completed word SHALL be latched into the left holding register (lrclk=0) or the right holding register (lrclk=1).
REQ-018 Completion of a right word SHALL form a pair with the latest left word; the pair SHALL reach out_left/out_right with out_valid=1 on the clk cycle after that rise_evt.
REQ-019 out_left/out_right/out_valid SHALL remain stable while out_valid=1 and out_ready=0.
REQ-020 A pair SHALL be accepted on any cycle where out_valid=1 and out_ready=1; out_valid SHALL then fall next cycle unless a new pair loads in that same cycle.
REQ-021 If a new pair completes while out_valid=1 and out_ready=0, the new pair SHALL be discarded, the presented pair kept, and overrun pulsed for one cycle.
REQ-022 If a new pair completes in the same cycle as an acceptance, the new pair SHALL load, out_valid SHALL stay 1, and overrun SHALL stay 0.
REQ-023 bclk and lrclk SHALL free-run independent of out_ready.

Reset
REQ-024 While rst=1: divider=0, bclk=0, lrclk=1, frame counter=2*SLOT_BITS-1, shift and holding registers=0, out_left=0, out_right=0, out_valid=0, overrun=0.
REQ-025 After rst is released, the first fall_evt SHALL enter left slot position 0, so the first pair is never partial.
REQ-026 Reset asserted mid-frame SHALL discard any partial words and any un-accepted pair.

Configuration
REQ-027 With I2S_RX_OVERRUN_CNT_EN defined, output overrun_cnt (16 bits) SHALL count overrun pulses, saturate at 0xFFFF, and reset to 0.
REQ-028 Without I2S_RX_OVERRUN_CNT_EN, port overrun_cnt and its counter SHALL be absent; all other behaviour is unchanged.

Verification
REQ-029 CLK_DIV_HALF=2, SLOT_BITS=32, SAMPLE_BITS=24, out_ready=1: bclk period SHALL be 4 clk, lrclk period 256 clk, and the first lrclk fall SHALL come 4 clk after reset release.
REQ-030 Same config, drive left 0xABCDEF and right 0x123456 MSB-first after the delay bit: out_left=0xABCDEF, out_right=0x123456, out_valid for 1 cycle, 1 clk after the right p=24 rise_evt.
REQ-031 Hold out_ready=0 for 3 frames (pairs A,B,C): A stays presented, overrun pulses twice, overrun_cnt=2 (macro on); raising out_ready then accepts A.
REQ-032 Raise out_ready exactly on pair B's load cycle while A is presented: A is accepted, B is presented next cycle, overrun=0.
REQ-033 Assert rst for 1 cycle at right slot p=10: all outputs return to reset values; the next pair (left 0x000001, right 0xFFFFFF) is captured exactly.
REQ-034 SLOT_BITS=16, SAMPLE_BITS=15, left 0x4001, right 0x7FFE: outputs match exactly; bits beyond p=15 are ignored.
